szeregowanie_wyjsc: RTL and testbench
=====================================

# szeregowanie_wyjsc

Serializer that sits directly downstream of the output demultiplexer. It takes the eight 8-bit output registers (`wyj0`..`wyj7`) and shifts them as one 64-bit frame into an external chain of 74HC595-type shift/latch registers driving the PLC's physical outputs. Physical outputs stay disabled (`oe_n` high) from reset until the first complete frame has been latched. Writes that arrive during a transfer are never lost: they trigger a re-send.

## Interface
- `DZIELNIK`, default 4: half-period of `sck` in `clk` cycles; legal range 1..255.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wyj0`..`wyj7` in 8 each: output register contents from the demultiplexer.
- `zadanie` in 1: refresh request; level-sampled every `clk` edge. Typically tied to the demultiplexer write strobe.
- `sdo` out 1: serial data to the chain.
- `sck` out 1: shift clock; the chain samples `sdo` on the rising edge of `sck`.
- `rclk` out 1: storage-register latch pulse.
- `oe_n` out 1: active-low output enable for the chain.
- `zajety` out 1: frame transfer in progress.
- `gotowe` out 1: one-cycle pulse when a frame has been latched.

## Operation
- Reset values: `sdo`=0, `sck`=0, `rclk`=0, `oe_n`=1, `zajety`=0, `gotowe`=0; internal pending flag=0; state `BEZCZYNNY`.
- States: `BEZCZYNNY`, `ZBOCZE_NISKIE`, `ZBOCZE_WYSOKIE`, `ZATRZASK`.
- `BEZCZYNNY` with `zadanie`=1 or pending=1, on that edge:
  - snapshot {wyj7,...,wyj0} into a 64-bit shift register (wyj7[7] is the MSB);
  - `sdo` takes the MSB;
  - bit counter=63, divider=0, `zajety`=1, pending cleared;
  - go to `ZBOCZE_NISKIE`.
- `ZBOCZE_NISKIE`: `sck`=0 for `DZIELNIK` cycles, then `sck`=1 and go to `ZBOCZE_WYSOKIE`.
- `ZBOCZE_WYSOKIE`: `sck`=1 for `DZIELNIK` cycles, then `sck`=0 and:
  - if bit counter=0: `rclk`=1, go to `ZATRZASK`;
  - otherwise: decrement the counter, shift left, `sdo`=new MSB, go to `ZBOCZE_NISKIE`.
- Shift order: wyj7[7] first, wyj0[0] last. 64 `sck` rising edges per frame, no more and no fewer.
- `ZATRZASK`: `rclk`=1 for `DZIELNIK` cycles. On the final edge of the phase:
  - `rclk`=0, `zajety`=0, `gotowe`=1 for one cycle;
  - `oe_n`=0, and it stays 0 until the next reset;
  - go to `BEZCZYNNY`.
- `zadanie`=1 while `zajety`=1 sets pending; multiple requests collapse into one.
  - The in-flight frame continues unchanged, using its snapshot.
  - A new frame starts from `BEZCZYNNY` on the next edge, with a fresh snapshot.
- Input changes on `wyj*` during a transfer do not affect the current frame.
- `zadanie` on the same edge that `gotowe` is asserted:
  - sets pending;
  - the next frame starts one cycle later.
- Reset mid-frame: all outputs return to their reset values immediately, so `oe_n`=1 and the physical outputs are disabled. No partial latch occurs because `rclk` is forced to 0.

## Timing
- `zadanie` sampled high at edge E0 in `BEZCZYNNY`:
  - `zajety`=1 and `sdo` valid from E0;
  - first `sck` rise at E0+`DZIELNIK`;
  - `sdo` changes only on `sck` falling edges, giving `DZIELNIK` cycles of setup and hold around each rise.
- Frame length is 129·`DZIELNIK` cycles:
  - `rclk` rises at E0+128·`DZIELNIK`;
  - `rclk` falls, `zajety` falls and `gotowe` pulses at E0+129·`DZIELNIK`.
- Back-to-back frames: the next E0 is E0+129·`DZIELNIK`+1.

## Structure
- Shared package `pakiet_io` holds:
  - the state enum `stan_szer_t`;
  - constant `LICZBA_BITOW_WYJ`=64;
  - constant `LICZBA_PORTOW_WYJ`=8.
- Sub-module `dzielnik_taktu`: a counter `0..DZIELNIK-1` with a synchronous clear, emitting a one-cycle `tik`. The FSM uses `tik` for every phase transition. Counter width is $clog2(DZIELNIK+1).

## Test plan
- Reset release, no `zadanie` → all outputs at reset values; `oe_n`=1 indefinitely.
- `DZIELNIK`=2, wyj7=8'hA5, others 0, one `zadanie` pulse:
  - 64 `sck` rises;
  - first eight `sdo` bits 1,0,1,0,0,1,0,1, rest 0;
  - `gotowe` at E0+258;
  - `oe_n`=0 afterwards.
- wyj0=8'h01 → only the 64th shifted bit is 1; the 595 model's Q-outputs after latch equal the concatenated input.
- `zadanie` pulsed 3 times during a frame, wyj3 changed to 8'h3C mid-frame:
  - the first frame carries the old value;
  - exactly one extra frame starts one cycle after `gotowe` and carries 8'h3C.
- `rst_n` asserted at bit 30 → asynchronously `sck`=`rclk`=0, `oe_n`=1, `zajety`=0; the next request runs a full 64-bit frame.
- `DZIELNIK`=1 → frame length 129 cycles; `sck` toggles every cycle; `gotowe` width exactly 1.

Source files
------------

// File: rtl/szeregowanie_wyjsc_pkg.sv
// ---------------------------------------------------------------------------
// pakiet_io -- shared definitions for the output path of the PLC.
//
// Holds the serializer state type and the frame geometry constants used by
// the output serializer (szeregowanie_wyjsc) and its helpers.
//   stan_szer_t        : serializer FSM states
//   LICZBA_BITOW_WYJ   : number of bits in one output frame (64)
//   LICZBA_PORTOW_WYJ  : number of 8-bit output registers (8)
// ---------------------------------------------------------------------------
package pakiet_io;

  localparam int LICZBA_BITOW_WYJ  = 64;
  localparam int LICZBA_PORTOW_WYJ = 8;

  typedef enum logic [1:0] {
    BEZCZYNNY      = 2'd0,
    ZBOCZE_NISKIE  = 2'd1,
    ZBOCZE_WYSOKIE = 2'd2,
    ZATRZASK       = 2'd3
  } stan_szer_t;

endpackage

// File: rtl/szeregowanie_wyjsc_dzielnik.sv
// ---------------------------------------------------------------------------
// dzielnik_taktu -- phase timer for the output serializer.
//
// Counts 0..DZIELNIK-1 and raises tik_o for exactly one clk cycle while the
// count sits at its last value, then wraps. A synchronous clear restarts the
// count at 0 so that a new phase always lasts a full DZIELNIK cycles.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   kasuj_i : synchronous clear (count forced to 0 on the next edge)
//   tik_o   : high in the last cycle of every DZIELNIK-cycle phase
// ---------------------------------------------------------------------------
module dzielnik_taktu #(
  parameter int DZIELNIK = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic kasuj_i,
  output logic tik_o
);

  localparam int SZER = $clog2(DZIELNIK + 1);
  localparam logic [SZER-1:0] OSTATNI = SZER'(DZIELNIK - 1);
  localparam logic [SZER-1:0] JEDEN   = SZER'(1);

  logic [SZER-1:0] licznik_q;
  logic [SZER-1:0] licznik_d;

  // With DZIELNIK=1 the count never leaves 0, so tik is permanently high
  // and every phase lasts a single cycle.
  always_comb begin
    licznik_d = licznik_q + JEDEN;
    if (kasuj_i || (licznik_q == OSTATNI)) begin
      licznik_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      licznik_q <= '0;
    end else begin
      licznik_q <= licznik_d;
    end
  end

  assign tik_o = (licznik_q == OSTATNI);

endmodule

// File: rtl/szeregowanie_wyjsc.sv
// ---------------------------------------------------------------------------
// szeregowanie_wyjsc -- 64-bit output serializer for a 74HC595 chain.
//
// On a refresh request it snapshots the eight output registers as one frame
// {wyj7,...,wyj0} (wyj7[7] is the MSB), shifts it MSB-first into the external
// chain with sck, then pulses rclk to latch it. The physical outputs stay
// disabled (oe_n high) from reset until the first frame has been latched.
// Requests arriving during a transfer are remembered (collapsed into one)
// and cause a fresh frame right after the current one finishes.
//
// Ports:
//   clk, rst_n      : system clock, asynchronous active-low reset
//   wyj0..wyj7      : output register contents from the demultiplexer
//   zadanie         : refresh request, level-sampled every clk edge
//   sdo, sck        : serial data / shift clock (chain samples on sck rise)
//   rclk            : storage-register latch pulse
//   oe_n            : active-low output enable for the chain
//   zajety          : frame transfer in progress
//   gotowe          : one-cycle pulse when a frame has been latched
// Parameter:
//   DZIELNIK        : half-period of sck in clk cycles (1..255)
// ---------------------------------------------------------------------------
module szeregowanie_wyjsc
  import pakiet_io::*;
#(
  parameter int DZIELNIK = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wyj0,
  input  logic [7:0] wyj1,
  input  logic [7:0] wyj2,
  input  logic [7:0] wyj3,
  input  logic [7:0] wyj4,
  input  logic [7:0] wyj5,
  input  logic [7:0] wyj6,
  input  logic [7:0] wyj7,
  input  logic       zadanie,
  output logic       sdo,
  output logic       sck,
  output logic       rclk,
  output logic       oe_n,
  output logic       zajety,
  output logic       gotowe
);

  localparam int SZER_LB = $clog2(LICZBA_BITOW_WYJ);
  localparam logic [SZER_LB-1:0] OSTATNI_BIT = SZER_LB'(LICZBA_BITOW_WYJ - 1);
  localparam logic [SZER_LB-1:0] JEDEN_BIT   = SZER_LB'(1);

  logic [LICZBA_PORTOW_WYJ-1:0][7:0] porty;
  logic [LICZBA_BITOW_WYJ-1:0]       ramka;

  stan_szer_t                  stan_q;
  logic [LICZBA_BITOW_WYJ-1:0] rej_q;
  logic [SZER_LB-1:0]          licznik_bitow_q;
  logic                        sck_q;
  logic                        rclk_q;
  logic                        oe_n_q;
  logic                        zajety_q;
  logic                        gotowe_q;
  logic                        oczekuje_q;

  logic tik;
  logic start;
  logic kasuj_dzielnik;

  // wyj7 lands in the top byte, so wyj7[7] is shifted out first.
  assign porty = {wyj7, wyj6, wyj5, wyj4, wyj3, wyj2, wyj1, wyj0};
  assign ramka = porty;

  assign start = (stan_q == BEZCZYNNY) && (zadanie || oczekuje_q);

  // The phase timer is held at 0 while idle, so the first low phase after
  // the snapshot edge lasts exactly DZIELNIK cycles.
  assign kasuj_dzielnik = (stan_q == BEZCZYNNY);

  dzielnik_taktu #(
    .DZIELNIK (DZIELNIK)
  ) u_dzielnik (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .kasuj_i (kasuj_dzielnik),
    .tik_o   (tik)
  );

  // Serializer FSM. The shift register is reset too: its MSB drives sdo
  // directly, and sdo must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stan_q          <= BEZCZYNNY;
      rej_q           <= '0;
      licznik_bitow_q <= '0;
      sck_q           <= 1'b0;
      rclk_q          <= 1'b0;
      oe_n_q          <= 1'b1;
      zajety_q        <= 1'b0;
      gotowe_q        <= 1'b0;
      oczekuje_q      <= 1'b0;
    end else begin
      gotowe_q <= 1'b0;

      // A request during a transfer (including the edge that ends it, where
      // zajety is still high) is remembered; repeats simply collapse.
      if (zadanie && zajety_q) begin
        oczekuje_q <= 1'b1;
      end

      unique case (stan_q)
        BEZCZYNNY: begin
          if (start) begin
            rej_q           <= ramka;
            licznik_bitow_q <= OSTATNI_BIT;
            sck_q           <= 1'b0;
            zajety_q        <= 1'b1;
            oczekuje_q      <= 1'b0;
            stan_q          <= ZBOCZE_NISKIE;
          end
        end

        ZBOCZE_NISKIE: begin
          if (tik) begin
            sck_q  <= 1'b1;
            stan_q <= ZBOCZE_WYSOKIE;
          end
        end

        ZBOCZE_WYSOKIE: begin
          if (tik) begin
            sck_q <= 1'b0;
            if (licznik_bitow_q == '0) begin
              rclk_q <= 1'b1;
              stan_q <= ZATRZASK;
            end else begin
              // Data moves only on the sck falling edge, giving a full
              // half-period of setup and hold around each rise.
              licznik_bitow_q <= licznik_bitow_q - JEDEN_BIT;
              rej_q           <= {rej_q[LICZBA_BITOW_WYJ-2:0], 1'b0};
              stan_q          <= ZBOCZE_NISKIE;
            end
          end
        end

        ZATRZASK: begin
          if (tik) begin
            rclk_q   <= 1'b0;
            zajety_q <= 1'b0;
            gotowe_q <= 1'b1;
            oe_n_q   <= 1'b0;
            stan_q   <= BEZCZYNNY;
          end
        end

        default: begin
          stan_q <= BEZCZYNNY;
        end
      endcase
    end
  end

  assign sdo    = rej_q[LICZBA_BITOW_WYJ-1];
  assign sck    = sck_q;
  assign rclk   = rclk_q;
  assign oe_n   = oe_n_q;
  assign zajety = zajety_q;
  assign gotowe = gotowe_q;

endmodule

// File: tb/tb_szeregowanie_wyjsc.sv
module tb_szeregowanie_wyjsc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] wyj [8];
  logic rst_n2, rst_n1, zad2, zad1;
  logic sdo2, sck2, rclk2, oen2, zaj2, got2;
  logic sdo1, sck1, rclk1, oen1, zaj1, got1;

  // Instance 0: DZIELNIK=2, instance 1: DZIELNIK=1
  szeregowanie_wyjsc #(.DZIELNIK(2)) u_d2 (
    .clk(clk), .rst_n(rst_n2),
    .wyj0(wyj[0]), .wyj1(wyj[1]), .wyj2(wyj[2]), .wyj3(wyj[3]),
    .wyj4(wyj[4]), .wyj5(wyj[5]), .wyj6(wyj[6]), .wyj7(wyj[7]),
    .zadanie(zad2), .sdo(sdo2), .sck(sck2), .rclk(rclk2),
    .oe_n(oen2), .zajety(zaj2), .gotowe(got2)
  );

  szeregowanie_wyjsc #(.DZIELNIK(1)) u_d1 (
    .clk(clk), .rst_n(rst_n1),
    .wyj0(wyj[0]), .wyj1(wyj[1]), .wyj2(wyj[2]), .wyj3(wyj[3]),
    .wyj4(wyj[4]), .wyj5(wyj[5]), .wyj6(wyj[6]), .wyj7(wyj[7]),
    .zadanie(zad1), .sdo(sdo1), .sck(sck1), .rclk(rclk1),
    .oe_n(oen1), .zajety(zaj1), .gotowe(got1)
  );

  logic [1:0] sdo_v, sck_v, rclk_v, oen_v, zaj_v, got_v;
  assign sdo_v  = {sdo1, sdo2};
  assign sck_v  = {sck1, sck2};
  assign rclk_v = {rclk1, rclk2};
  assign oen_v  = {oen1, oen2};
  assign zaj_v  = {zaj1, zaj2};
  assign got_v  = {got1, got2};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model of the external 74HC595 chain: shift on sck rise,
  // copy to the storage register on rclk rise.
  logic [63:0] chain [2] = '{64'd0, 64'd0};
  logic [63:0] q595  [2] = '{64'd0, 64'd0};
  int rises   [2] = '{0, 0};
  int latches [2] = '{0, 0};
  int viol    [2] = '{0, 0};
  logic sck_p [2] = '{1'b0, 1'b0};
  logic rclk_p[2] = '{1'b0, 1'b0};
  logic sdo_p [2] = '{1'b0, 1'b0};
  logic zaj_p [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sck_v[i] && !sck_p[i]) begin
        chain[i] <= {chain[i][62:0], sdo_v[i]};
        rises[i] <= rises[i] + 1;
      end
      if (rclk_v[i] && !rclk_p[i]) begin
        q595[i]    <= chain[i];
        latches[i] <= latches[i] + 1;
      end
      // Mid-frame, sdo may only move together with a falling sck.
      if ((sdo_v[i] !== sdo_p[i]) && zaj_p[i] && zaj_v[i] && !(sck_p[i] && !sck_v[i]))
        viol[i] <= viol[i] + 1;
      sck_p[i]  <= sck_v[i];
      rclk_p[i] <= rclk_v[i];
      sdo_p[i]  <= sdo_v[i];
      zaj_p[i]  <= zaj_v[i];
    end
  end

  function automatic logic [63:0] ramka_ref();
    logic [63:0] r = 64'd0;
    for (int k = 7; k >= 0; k--) r = {r[55:0], wyj[k]};
    return r;
  endfunction

  task automatic set_zad(input int inst, input logic v);
    if (inst == 0) zad2 = v; else zad1 = v;
  endtask

  task automatic start_frame(input int inst);
    @(negedge clk); set_zad(inst, 1'b1);
    @(negedge clk); set_zad(inst, 1'b0);
  endtask

  // Counts clk edges until gotowe (the first edge counted is E0+1).
  task automatic wait_gotowe(input int inst, output int n, output int tog);
    logic s;
    s = sck_v[inst];
    n = 0; tog = 0;
    while (!got_v[inst] && n < 3000) begin
      @(negedge clk);
      n++;
      if (sck_v[inst] !== s) tog++;
      s = sck_v[inst];
    end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL timeout_gotowe: inst %0d got no gotowe after %0d cycles", inst, n);
    end
  endtask

  task automatic do_frame(input int inst, input int d, input logic [63:0] exp, input string tag);
    int r0, l0, n, tog;
    r0 = rises[inst]; l0 = latches[inst];
    start_frame(inst);
    chk({tag, "_zajety_at_E0"}, 64'(zaj_v[inst]), 64'd1);
    chk({tag, "_sdo_msb_at_E0"}, 64'(sdo_v[inst]), 64'(exp[63]));
    wait_gotowe(inst, n, tog);
    chk({tag, "_gotowe_time"}, 64'(n), 64'(129 * d));
    chk({tag, "_sck_toggles"}, 64'(tog), 64'd128);
    chk({tag, "_q595"}, q595[inst], exp);
    chk({tag, "_sck_rises"}, 64'(rises[inst] - r0), 64'd64);
    chk({tag, "_latches"}, 64'(latches[inst] - l0), 64'd1);
    chk({tag, "_oe_n"}, 64'(oen_v[inst]), 64'd0);
    chk({tag, "_zajety_end"}, 64'(zaj_v[inst]), 64'd0);
    @(negedge clk);
    chk({tag, "_gotowe_width"}, 64'(got_v[inst]), 64'd0);
  endtask

  typedef struct {
    logic [7:0]  w [8];
    logic [63:0] exp;
  } vec_t;

  vec_t tab [5];

  initial begin
    logic [63:0] e_old, e_new, e_r;
    int n, tog, r0, l0, k;

    tab[0].w = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
    tab[0].exp = 64'hA500_0000_0000_0000;
    tab[1].w = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tab[1].exp = 64'h0000_0000_0000_0001;
    tab[2].w = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tab[2].exp = 64'hFFFF_FFFF_FFFF_FFFF;
    tab[3].w = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    tab[3].exp = 64'h0123_4567_89AB_CDEF;
    tab[4].w = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
    tab[4].exp = 64'h8000_0000_0000_0001;

    rst_n2 = 1'b0; rst_n1 = 1'b0; zad2 = 1'b0; zad1 = 1'b0;
    for (int i = 0; i < 8; i++) wyj[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n2 = 1'b1; rst_n1 = 1'b1;
    repeat (20) @(negedge clk);

    // Idle after reset: everything at reset values, outputs disabled
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_sdo", i),    64'(sdo_v[i]),  64'd0);
      chk($sformatf("rst%0d_sck", i),    64'(sck_v[i]),  64'd0);
      chk($sformatf("rst%0d_rclk", i),   64'(rclk_v[i]), 64'd0);
      chk($sformatf("rst%0d_oe_n", i),   64'(oen_v[i]),  64'd1);
      chk($sformatf("rst%0d_zajety", i), 64'(zaj_v[i]),  64'd0);
      chk($sformatf("rst%0d_gotowe", i), 64'(got_v[i]),  64'd0);
    end

    // Table-driven frames on both dividers
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 8; i++) wyj[i] = tab[v].w[i];
      do_frame(0, 2, tab[v].exp, $sformatf("tab%0d_d2", v));
      do_frame(1, 1, tab[v].exp, $sformatf("tab%0d_d1", v));
    end

    // Three requests during a frame, wyj3 changed mid-frame
    for (int i = 0; i < 8; i++) wyj[i] = 8'($urandom);
    wyj[3] = 8'h11;
    e_old = ramka_ref();
    l0 = latches[0];
    start_frame(0);
    repeat (40) @(negedge clk);
    start_frame(0);
    wyj[3] = 8'h3C;
    e_new = ramka_ref();
    repeat (60) @(negedge clk);
    start_frame(0);
    repeat (100) @(negedge clk);
    start_frame(0);
    wait_gotowe(0, n, tog);
    chk("pend_first_frame_old", q595[0], e_old);
    chk("pend_zajety_at_gotowe", 64'(zaj_v[0]), 64'd0);
    @(negedge clk);
    chk("pend_restart_next_cycle", 64'(zaj_v[0]), 64'd1);
    r0 = rises[0];
    wait_gotowe(0, n, tog);
    chk("pend_second_time", 64'(n), 64'd258);
    chk("pend_second_frame_new", q595[0], e_new);
    chk("pend_second_rises", 64'(rises[0] - r0), 64'd64);
    repeat (400) @(negedge clk);
    chk("pend_only_one_extra", 64'(latches[0] - l0), 64'd2);
    chk("pend_idle_after", 64'(zaj_v[0]), 64'd0);

    // Request sampled on the very edge gotowe is asserted
    for (int i = 0; i < 8; i++) wyj[i] = 8'($urandom);
    e_old = ramka_ref();
    start_frame(0);
    repeat (257) @(negedge clk);
    zad2 = 1'b1;
    @(negedge clk);
    chk("same_edge_gotowe", 64'(got_v[0]), 64'd1);
    chk("same_edge_frame1", q595[0], e_old);
    zad2 = 1'b0;
    for (int i = 0; i < 8; i++) wyj[i] = 8'($urandom);
    e_new = ramka_ref();
    @(negedge clk);
    chk("same_edge_restart", 64'(zaj_v[0]), 64'd1);
    wait_gotowe(0, n, tog);
    chk("same_edge_time2", 64'(n), 64'd258);
    chk("same_edge_frame2", q595[0], e_new);
    @(negedge clk);

    // Asynchronous reset at bit 30 while sck is high
    for (int i = 0; i < 8; i++) wyj[i] = 8'($urandom);
    e_r = ramka_ref();
    l0 = latches[0];
    start_frame(0);
    r0 = rises[0];
    k = 0;
    while (!((rises[0] - r0 == 30) && sck_v[0]) && k < 2000) begin
      @(negedge clk); k++;
    end
    chk("rst_mid_reached_bit30", 64'(rises[0] - r0), 64'd30);
    #2 rst_n2 = 1'b0;
    #1;
    chk("rst_mid_sck",    64'(sck_v[0]),  64'd0);
    chk("rst_mid_rclk",   64'(rclk_v[0]), 64'd0);
    chk("rst_mid_oe_n",   64'(oen_v[0]),  64'd1);
    chk("rst_mid_zajety", 64'(zaj_v[0]),  64'd0);
    chk("rst_mid_sdo",    64'(sdo_v[0]),  64'd0);
    @(negedge clk); rst_n2 = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_after_oe_n", 64'(oen_v[0]), 64'd1);
    chk("rst_no_latch", 64'(latches[0] - l0), 64'd0);
    do_frame(0, 2, e_r, "rst_full_frame");

    // Random frames against the chain model
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) wyj[i] = 8'($urandom);
      do_frame(r % 2, (r % 2 == 0) ? 2 : 1, ramka_ref(), $sformatf("rnd%0d", r));
    end

    chk("sdo_timing_d2", 64'(viol[0]), 64'd0);
    chk("sdo_timing_d1", 64'(viol[1]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
